// File: rtl/switch_debouncer.sv
// Switch conditioner: two-flop synchronizer, 4-state debounce FSM, level plus press/release pulses.
// Define SW_AUTOREPEAT_EN to add auto-repeat SW_PRESS pulses while the switch stays pressed.
module switch_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter bit SW_ACTIVE_HIGH  = 1'b1,
    parameter int REPEAT_DELAY    = 5000000,
    parameter int REPEAT_PERIOD   = 2000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic SW_IN,
    output logic SW_LEVEL,
    output logic SW_PRESS,
    output logic SW_RELEASE
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_PEND,
        PRESSED,
        RELEASE_PEND
    } state_t;

    generate
        if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_params
            $error("switch_debouncer: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 2");
        end
    endgenerate

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             sw_pressed;
    logic             sync1;
    logic             sync2;

    assign sw_pressed = SW_ACTIVE_HIGH ? SW_IN : ~SW_IN;

`ifdef SW_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_count;
    logic             repeating;  // first repeat uses REPEAT_DELAY, later ones REPEAT_PERIOD
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= sw_pressed;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            count      <= '0;
            SW_LEVEL   <= 1'b0;
            SW_PRESS   <= 1'b0;
            SW_RELEASE <= 1'b0;
`ifdef SW_AUTOREPEAT_EN
            rep_count  <= '0;
            repeating  <= 1'b0;
`endif
        end else begin
            // NOTE: pulses default low each cycle so any set below lasts exactly one clock.
            SW_PRESS   <= 1'b0;
            SW_RELEASE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sync2) begin
                        state <= PRESS_PEND;
                        count <= '0;
                    end
                end
                PRESS_PEND: begin
                    if (!sync2) begin
                        state <= IDLE;
                        count <= '0;
                    end else if (count == CNT_LAST) begin
                        state    <= PRESSED;
                        count    <= '0;
                        SW_LEVEL <= 1'b1;
                        SW_PRESS <= 1'b1;
`ifdef SW_AUTOREPEAT_EN
                        rep_count <= '0;
                        repeating <= 1'b0;
`endif
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!sync2) begin
                        state <= RELEASE_PEND;
                        count <= '0;
                    end else begin
`ifdef SW_AUTOREPEAT_EN
                        if (rep_count == (repeating ? PERIOD_LAST : DELAY_LAST)) begin
                            SW_PRESS  <= 1'b1;
                            rep_count <= '0;
                            repeating <= 1'b1;
                        end else begin
                            rep_count <= rep_count + 1'b1;
                        end
`endif
                    end
                end
                RELEASE_PEND: begin
                    // A release glitch returns to PRESSED with the repeat count untouched.
                    if (sync2) begin
                        state <= PRESSED;
                        count <= '0;
                    end else if (count == CNT_LAST) begin
                        state      <= IDLE;
                        count      <= '0;
                        SW_LEVEL   <= 1'b0;
                        SW_RELEASE <= 1'b1;
`ifdef SW_AUTOREPEAT_EN
                        rep_count  <= '0;
                        repeating  <= 1'b0;
`endif
                    end else begin
                        count <= count + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_switch_debouncer.sv
// Bench for switch_debouncer: directed scenarios with literal expectations plus
// randomized switch activity compared every cycle against a run-length reference model.
module tb_switch_debouncer;

    localparam int D  = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic CLK = 1'b0;
    logic RST;
    logic SW_IN;
    logic SW_LEVEL;
    logic SW_PRESS;
    logic SW_RELEASE;

    int checks   = 0;
    int failures = 0;

    // Reference model state: inputs seen at the last two edges, accepted level,
    // length of the current run of samples disagreeing with the level, held-press count.
    bit pipe[$];
    bit m_level;
    int m_run;
    int m_hold;
    bit m_press;
    bit m_rel;
    int n_press;
    int n_rel;

    always #10 CLK = ~CLK;

    switch_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .SW_ACTIVE_HIGH (1'b1),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SW_IN     (SW_IN),
        .SW_LEVEL  (SW_LEVEL),
        .SW_PRESS  (SW_PRESS),
        .SW_RELEASE(SW_RELEASE)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0d required=%0d", name, $time, act, exp);
        end
    endtask

    // A new level is accepted once D+1 consecutive observed samples (input delayed
    // by two edges) disagree with the current level.
    task automatic model_edge(input bit sw, input bit rst);
        bit obs;
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (rst) begin
            pipe    = '{1'b0, 1'b0};
            m_level = 1'b0;
            m_run   = 0;
            m_hold  = 0;
            return;
        end
        obs = pipe.pop_front();
        pipe.push_back(sw);
        if (obs != m_level) begin
            m_run++;
            if (m_run == D + 1) begin
                m_level = obs;
                m_run   = 0;
                m_hold  = 0;
                if (obs) m_press = 1'b1;
                else     m_rel   = 1'b1;
            end
        end else begin
            if (m_level && m_run == 0) begin
                m_hold++;
`ifdef SW_AUTOREPEAT_EN
                if (m_hold >= RD && (m_hold - RD) % RP == 0) m_press = 1'b1;
`endif
            end
            m_run = 0;
        end
    endtask

    task automatic step(input bit sw, input bit rst);
        SW_IN = sw;
        RST   = rst;
        @(posedge CLK);
        model_edge(sw, rst);
        @(negedge CLK);
        check("model_level",   SW_LEVEL,   m_level);
        check("model_press",   SW_PRESS,   m_press);
        check("model_release", SW_RELEASE, m_rel);
        if (SW_PRESS)   n_press++;
        if (SW_RELEASE) n_rel++;
    endtask

    function automatic bit hold_press_expected(input int e);
`ifdef SW_AUTOREPEAT_EN
        return (e == 7) || (e == 27) || (e == 35) || (e == 43) || (e == 51) || (e == 59);
`else
        return (e == 7);
`endif
    endfunction

    initial begin
        bit sw;
        int len;
        pipe = '{1'b0, 1'b0};

        // Reset state
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        check("reset_level",   SW_LEVEL,   1'b0);
        check("reset_press",   SW_PRESS,   1'b0);
        check("reset_release", SW_RELEASE, 1'b0);

        // Clean press, then held (auto-repeat pulses when enabled)
        for (int e = 1; e <= 64; e++) begin
            step(1'b1, 1'b0);
            check("clean_press",   SW_PRESS,   hold_press_expected(e));
            check("clean_level",   SW_LEVEL,   e >= 7);
            check("clean_release", SW_RELEASE, 1'b0);
        end

        // Clean release
        for (int e = 1; e <= 10; e++) begin
            step(1'b0, 1'b0);
            check("rel_release", SW_RELEASE, e == 7);
            check("rel_level",   SW_LEVEL,   e < 7);
            check("rel_press",   SW_PRESS,   1'b0);
        end

        // Bounce: 1,1,0,0,1,1,0,0 then held high
        for (int i = 0; i < 8; i++) begin
            step(((i / 2) % 2) == 0, 1'b0);
            check("bounce_quiet", SW_PRESS, 1'b0);
        end
        for (int e = 1; e <= 12; e++) begin
            step(1'b1, 1'b0);
            check("bounce_press", SW_PRESS, e == 7);
            check("bounce_level", SW_LEVEL, e >= 7);
        end
        for (int e = 1; e <= 10; e++) step(1'b0, 1'b0);

        // Short glitch: three high samples never accepted
        for (int i = 0; i < 13; i++) begin
            step(i < 3, 1'b0);
            check("glitch_level",   SW_LEVEL,   1'b0);
            check("glitch_press",   SW_PRESS,   1'b0);
            check("glitch_release", SW_RELEASE, 1'b0);
        end

        // Eight press/release cycles
        n_press = 0;
        n_rel   = 0;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 10; j++) step(1'b1, 1'b0);
            for (int j = 0; j < 10; j++) step(1'b0, 1'b0);
        end
        check("eight_presses",  n_press, 8);
        check("eight_releases", n_rel,   8);

        // Reset while in PRESS_PEND with count = 2, switch held through reset
        for (int e = 1; e <= 5; e++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("midrst_level",   SW_LEVEL,   1'b0);
        check("midrst_press",   SW_PRESS,   1'b0);
        check("midrst_release", SW_RELEASE, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            step(1'b1, 1'b0);
            check("midrst_repress", SW_PRESS, e == 7);
            check("midrst_relevel", SW_LEVEL, e >= 7);
        end
        for (int e = 1; e <= 10; e++) step(1'b0, 1'b0);

        // Randomized runs of random length with occasional resets
        for (int i = 0; i < 400; i++) begin
            sw  = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40)) : int'($urandom_range(1, 8));
            for (int j = 0; j < len; j++) step(sw, $urandom_range(0, 199) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
